// File: rtl/chu_video_stream_pkg.sv
// chu_video_stream_pkg: shared FSM states, register offsets and ctrl field positions for the stream monitor.
package chu_video_stream_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_SOF = 2'd1, ACTIVE = 2'd2, DONE = 2'd3} state_e;
  localparam logic [2:0] REG_CTRL = 3'd0, REG_STATUS = 3'd1, REG_CKSUM = 3'd2;
  localparam logic [2:0] REG_FRAMES = 3'd3, REG_ERRS = 3'd4, REG_LAST = 3'd5;
  localparam int CTRL_EN = 0, CTRL_CONT = 1, CTRL_T_LSB = 8, CTRL_T_MSB = 15;
  function automatic logic [31:0] rotl1(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction
endpackage

// File: rtl/chu_video_stream_monitor_if.sv
// chu_video_stream_monitor_if: slot register bus plus valid/ready pixel stream.
interface chu_video_stream_monitor_if #(parameter int CD = 12);
  logic cs, read, write;
  logic [13:0] addr;
  logic [31:0] wr_data, rd_data;
  logic [CD:0] si_data;
  logic si_valid, si_ready;
  modport master(output cs, read, write, addr, wr_data, si_data, si_valid, input rd_data, si_ready);
  modport slave(input cs, read, write, addr, wr_data, si_data, si_valid, output rd_data, si_ready);
endinterface

// File: rtl/stream_cksum32.sv
// stream_cksum32: rotate-and-add checksum; clear with enable restarts the sum at the incoming word.
module stream_cksum32 import chu_video_stream_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] sum_o
);
  logic [31:0] sum_q, sum_d;
  always_comb sum_d = clr_i ? (en_i ? data_i : 32'd0) : en_i ? rotl1(sum_q) + data_i : sum_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) sum_q <= '0;
    else sum_q <= sum_d;
  assign sum_o = sum_q;
endmodule

// File: rtl/chu_video_stream_monitor.sv
// chu_video_stream_monitor: frame/SOF checker with throttled ready and register readback.
// Checksum accumulator is built only when STREAM_MON_CKSUM_EN is defined; otherwise offset 2 reads 0.
module chu_video_stream_monitor import chu_video_stream_pkg::*; #(
  parameter int CD   = 12,
  parameter int HMAX = 640,
  parameter int VMAX = 480
) (
  input logic clk,
  input logic reset,
  chu_video_stream_monitor_if.slave bus
);
  state_e      state_q, state_d;
  logic        en_q, en_d, cont_q, cont_d, done_q, done_d, err_seen_q, err_seen_d;
  logic [7:0]  tset_q, tset_d, thr_q, thr_d;
  logic [15:0] x_q, x_d, y_q, y_d, cx, cy, nx, ny;
  logic [31:0] frames_q, frames_d, errs_q, errs_d, last_q, last_d, pos, cks;
  logic        ctrl_wr, acc, sof, go, ev_start, ev_pix, ev_err, ev_last;
  assign ctrl_wr  = bus.cs & bus.write & (bus.addr[2:0] == REG_CTRL);
  assign acc      = bus.si_valid & bus.si_ready;
  assign sof      = bus.si_data[0];
  assign go       = en_q & ~ctrl_wr;
  assign ev_start = go & acc & sof & (state_q == WAIT_SOF);
  assign ev_pix   = go & acc & (state_q == ACTIVE);
  assign pos      = 32'(y_q) * 32'(HMAX) + 32'(x_q);
  assign ev_err   = ev_pix & sof & (pos != 32'd0);
  // A misplaced SOF is treated as pixel 0 of a new frame
  assign cx       = ev_err ? 16'd0 : x_q;
  assign cy       = ev_err ? 16'd0 : y_q;
  assign nx       = cx == 16'(HMAX - 1) ? 16'd0 : cx + 16'd1;
  assign ny       = cx == 16'(HMAX - 1) ? cy + 16'd1 : cy;
  assign ev_last  = ev_pix & (cx == 16'(HMAX - 1)) & (cy == 16'(VMAX - 1));
  assign bus.si_ready = (state_q == WAIT_SOF) | ((state_q == ACTIVE) & (thr_q == 8'd0));
  always_comb begin
    state_d    = ctrl_wr ? (bus.wr_data[CTRL_EN] ? WAIT_SOF : IDLE) :
                 !en_q ? IDLE :
                 state_q == IDLE ? WAIT_SOF :
                 ev_start ? ACTIVE :
                 ev_last ? DONE :
                 (state_q == DONE) & cont_q ? WAIT_SOF : state_q;
    en_d       = ctrl_wr ? bus.wr_data[CTRL_EN] : en_q;
    cont_d     = ctrl_wr ? bus.wr_data[CTRL_CONT] : cont_q;
    tset_d     = ctrl_wr ? bus.wr_data[CTRL_T_MSB:CTRL_T_LSB] : tset_q;
    thr_d      = state_q != ACTIVE ? 8'd0 : bus.si_ready ? tset_q : thr_q - 8'd1;
    x_d        = state_d != ACTIVE ? 16'd0 : (ev_start | ev_pix) ? nx : x_q;
    y_d        = state_d != ACTIVE ? 16'd0 : (ev_start | ev_pix) ? ny : y_q;
    done_d     = ctrl_wr ? 1'b0 : ev_last | done_q;
    err_seen_d = ctrl_wr ? 1'b0 : ev_err | err_seen_q;
    frames_d   = ev_last ? frames_q + 32'd1 : frames_q;
    errs_d     = ev_err & ~&errs_q ? errs_q + 32'd1 : errs_q;
    last_d     = ev_last ? 32'(HMAX * VMAX) : ev_err ? pos : last_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE; en_q <= 1'b0; cont_q <= 1'b0; tset_q <= '0; thr_q <= '0;
      x_q <= '0; y_q <= '0; done_q <= 1'b0; err_seen_q <= 1'b0;
      frames_q <= '0; errs_q <= '0; last_q <= '0;
    end else begin
      state_q <= state_d; en_q <= en_d; cont_q <= cont_d; tset_q <= tset_d; thr_q <= thr_d;
      x_q <= x_d; y_q <= y_d; done_q <= done_d; err_seen_q <= err_seen_d;
      frames_q <= frames_d; errs_q <= errs_d; last_q <= last_d;
    end
`ifdef STREAM_MON_CKSUM_EN
  stream_cksum32 u_cksum (
    .clk(clk), .reset(reset),
    .clr_i(ctrl_wr | ev_err | ((state_q == DONE) & cont_q)),
    .en_i(ev_start | ev_pix),
    .data_i(32'(bus.si_data[CD:1])),
    .sum_o(cks)
  );
`else
  assign cks = 32'd0;
`endif
  always_comb begin
    bus.rd_data = 32'd0;
    case (bus.addr[2:0])
      REG_CTRL:   bus.rd_data = {16'd0, tset_q, 6'd0, cont_q, en_q};
      REG_STATUS: bus.rd_data = {28'd0, state_q, err_seen_q, done_q};
      REG_CKSUM:  bus.rd_data = cks;
      REG_FRAMES: bus.rd_data = frames_q;
      REG_ERRS:   bus.rd_data = errs_q;
      REG_LAST:   bus.rd_data = last_q;
      default:    bus.rd_data = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_chu_video_stream_monitor.sv
// tb_chu_video_stream_monitor: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_chu_video_stream_monitor;
  localparam int CD = 12, HMAX = 4, VMAX = 2;
  logic clk = 1'b0, reset = 1'b1, probe = 1'b0;
  int checks = 0, errors = 0;
  typedef struct {string name; logic [31:0] v;} exp_t;
  exp_t rq[$], sq[$];
  always #5 clk = ~clk;
  chu_video_stream_monitor_if #(.CD(CD)) bus();
  chu_video_stream_monitor #(.CD(CD), .HMAX(HMAX), .VMAX(VMAX)) dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic void cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", n, act, exp);
    end
  endfunction
  function automatic logic [31:0] cks_of(input int base, input int n);
    logic [31:0] c = 32'd0;
    for (int i = 0; i < n; i++) c = {c[30:0], c[31]} + 32'(base + i);
`ifndef STREAM_MON_CKSUM_EN
    c = 32'd0;
`endif
    return c;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (bus.cs && bus.read) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: read with no expectation queued");
      end else begin
        e = rq.pop_front();
        cmp(e.name, bus.rd_data, e.v);
      end
    end
    if (probe) begin
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdy_unexpected: probe with no expectation queued");
      end else begin
        e = sq.pop_front();
        cmp(e.name, 32'(bus.si_ready), e.v);
      end
    end
  end
  task automatic rd(input logic [2:0] a, input logic [31:0] v, input string n);
    exp_t e;
    e.name = n; e.v = v; rq.push_back(e);
    bus.cs = 1'b1; bus.read = 1'b1; bus.addr = {11'd0, a};
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.read = 1'b0;
  endtask
  task automatic wr(input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 14'd0; bus.wr_data = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask
  task automatic rdy(input logic v, input string n);
    exp_t e;
    e.name = n; e.v = 32'(v); sq.push_back(e);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask
  task automatic pix(input int rgb, input logic sof);
    int n;
    n = 0;
    bus.si_data = {12'(rgb), sof}; bus.si_valid = 1'b1;
    @(negedge clk);
    while (!bus.si_ready && n < 40) begin n++; @(negedge clk); end
    checks++;
    if (!bus.si_ready) begin
      errors++;
      $display("FAIL pix_accept: si_ready=0 after %0d cycles, want 1", n);
    end
    @(posedge clk); #1;
  endtask
  task automatic frame(input int base);
    for (int i = 0; i < 8; i++) pix(base + i, i == 0);
    bus.si_valid = 1'b0;
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cs = 0; bus.read = 0; bus.write = 0; bus.addr = '0; bus.wr_data = '0;
    bus.si_data = '0; bus.si_valid = 0;
    @(posedge clk); #1;
    for (int a = 0; a < 6; a++) rd(3'(a), 32'd0, $sformatf("reset_reg%0d", a));
    rdy(1'b0, "reset_rdy");
    reset = 1'b0;
    // basic frame, preceded by a non-SOF pixel that must be discarded
    wr(32'h1);
    pix(12'hAAA, 1'b0);
    frame(1);
    rd(3'd1, 32'hD, "f1_status");
    rd(3'd3, 32'd1, "f1_frames");
    rd(3'd5, 32'd8, "f1_last");
    rd(3'd4, 32'd0, "f1_errs");
    rd(3'd2, cks_of(1, 8), "f1_cks");
    rdy(1'b0, "f1_rdy_done");
    // throttle T=2: ready 1,0,0 repeating while ACTIVE
    wr(32'h0201);
    rd(3'd0, 32'h201, "t2_ctrl");
    pix(1, 1'b1);
    fork
      for (int i = 2; i < 8; i++) pix(i, 1'b0);
      begin
        rdy(1, "t2_rdy0"); rdy(0, "t2_rdy1"); rdy(0, "t2_rdy2");
        rdy(1, "t2_rdy3"); rdy(0, "t2_rdy4"); rdy(0, "t2_rdy5");
      end
    join
    rd(3'd1, 32'h8, "t2_status_7acc");
    pix(8, 1'b0);
    bus.si_valid = 1'b0;
    rd(3'd1, 32'hD, "t2_status");
    rd(3'd3, 32'd2, "t2_frames");
    rd(3'd2, cks_of(1, 8), "t2_cks");
    // SOF on the 5th pixel restarts the frame
    wr(32'h1);
    pix(1, 1'b1); pix(2, 1'b0); pix(3, 1'b0); pix(4, 1'b0); pix(5, 1'b1);
    bus.si_valid = 1'b0;
    rd(3'd5, 32'd4, "e_last_mid");
    rd(3'd4, 32'd1, "e_errs");
    rd(3'd1, 32'hA, "e_status_mid");
    for (int i = 6; i < 13; i++) pix(i, 1'b0);
    bus.si_valid = 1'b0;
    rd(3'd1, 32'hF, "e_status");
    rd(3'd5, 32'd8, "e_last");
    rd(3'd3, 32'd3, "e_frames");
    rd(3'd2, cks_of(5, 8), "e_cks");
    // continuous mode: checksum is read during the single DONE cycle
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    wr(32'h3);
    frame(1);
    frame(16);
    rd(3'd2, cks_of(16, 8), "c_cks_frame2");
    rd(3'd2, 32'd0, "c_cks_cleared");
    rd(3'd3, 32'd2, "c_frames");
    rd(3'd1, 32'h5, "c_status");
    // reset in the middle of the 3rd pixel
    wr(32'h1);
    pix(1, 1'b1); pix(2, 1'b0);
    bus.si_data = {12'd3, 1'b0}; bus.si_valid = 1'b1;
    #2 reset = 1'b1;
    bus.si_valid = 1'b0;
    rdy(1'b0, "r_rdy");
    for (int a = 0; a < 6; a++) rd(3'(a), 32'd0, $sformatf("r_reg%0d", a));
    reset = 1'b0;
    wr(32'h1);
    frame(1);
    rd(3'd1, 32'hD, "r_status");
    rd(3'd3, 32'd1, "r_frames");
    rd(3'd5, 32'd8, "r_last");
    rd(3'd4, 32'd0, "r_errs");
    rd(3'd2, cks_of(1, 8), "r_cks");
    // ctrl write coincident with the last acceptance wins
    wr(32'h1);
    for (int i = 1; i < 8; i++) pix(i, i == 1);
    bus.si_data = {12'd8, 1'b0}; bus.si_valid = 1'b1;
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 14'd0; bus.wr_data = 32'h1;
    rdy(1'b1, "w_rdy_last");
    bus.cs = 1'b0; bus.write = 1'b0; bus.si_valid = 1'b0;
    rd(3'd1, 32'h4, "w_status");
    rd(3'd3, 32'd1, "w_frames");
    rd(3'd2, 32'd0, "w_cks");
    // disable returns to IDLE, counters kept
    wr(32'h0);
    rd(3'd1, 32'h0, "d_status");
    rd(3'd3, 32'd1, "d_frames");
    rd(3'd7, 32'd0, "d_offset7");
    rdy(1'b0, "d_rdy");
    repeat (2) @(posedge clk);
    if (rq.size() != 0 || sq.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d reads, %0d probes left, want 0", rq.size(), sq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
